inst_prefetch: RTL and testbench

INST_PREFETCH -- requirements
Module: inst_prefetch

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/inst_fifo.sv | 57 +++++
 rtl/inst_prefetch.sv | 116 +++++++++++
 tb/tb_inst_prefetch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and helpers used by the fetch front end.
package cpu_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  // Prefetch FSM: issuing byte reads, or waiting for a FIFO slot
  typedef enum logic {
    StRun   = 1'b0,
    StStall = 1'b1
  } pf_state_e;

  // Instructions are word aligned; drop the byte offset
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Instruction FIFO: power-of-two depth, synchronous flush, registered occupancy count.
module inst_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  // Occupancy flags and guarded push/pop
  always_comb begin
    full    = (count_q == (AW+1)'(DEPTH));
    empty   = (count_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    count   = count_q;
    rdata   = mem_q[rd_ptr_q];
  end

  // Storage array; contents need no reset since reads are qualified by empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers and count; flush discards everything, overriding push and pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: assembles big-endian 32-bit words from a byte-wide memory
// (one read per cycle, data one cycle later) and queues them with their PC.
// Optional feature macro INST_PREFETCH_ALIGN_ERR_EN adds the align_err output.
module inst_prefetch
  import cpu_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   mem_addr,
  output logic              mem_rden,
  input  logic [7:0]        mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc
`ifdef INST_PREFETCH_ALIGN_ERR_EN
  ,
  output logic              align_err
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  pf_state_e        state_q;
  logic [PC_W-1:0]  fetch_pc_q, rd_pc_q;
  logic [1:0]       byte_cnt_q, rd_idx_q;
  logic             rd_pend_q;
  logic [23:0]      asm_q;

  logic [CW-1:0]    fifo_count, free_slots, asm_words;
  logic             fifo_full, fifo_empty;
  logic [INST_W+PC_W-1:0] fifo_rdata;
  logic             ret_last, can_start, issue, push, pop;

  // Issue/push decisions; a new word starts only if a slot is left beyond words in flight
  always_comb begin
    ret_last   = rd_pend_q && (rd_idx_q == 2'd3);
    free_slots = CW'(DEPTH) - fifo_count;
    asm_words  = {{(CW-1){1'b0}}, ret_last};
    can_start  = free_slots > asm_words;
    issue      = !rst && !redirect && (state_q == StRun) && ((byte_cnt_q != 2'd0) || can_start);
    mem_rden   = issue;
    mem_addr   = fetch_pc_q + {14'b0, byte_cnt_q};
    push       = ret_last && !redirect && !fifo_full;
    pop        = inst_valid && inst_ready;
    inst_valid = !fifo_empty;
    inst       = fifo_empty ? '0 : fifo_rdata[INST_W+PC_W-1:PC_W];
    inst_pc    = fifo_empty ? '0 : fifo_rdata[PC_W-1:0];
  end

  // Fetch FSM, byte sequencing and word assembly; redirect overrides everything but reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      byte_cnt_q <= 2'd0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= 2'd0;
      rd_pc_q    <= '0;
      asm_q      <= '0;
    end else if (redirect) begin
      state_q    <= StRun;
      fetch_pc_q <= align_pc(redirect_pc);
      byte_cnt_q <= 2'd0;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_pend_q <= issue;
      if (issue) begin
        rd_idx_q   <= byte_cnt_q;
        rd_pc_q    <= fetch_pc_q;
        byte_cnt_q <= byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          fetch_pc_q <= fetch_pc_q + 16'd4;
          // Only the word just completed is in flight; stall if it takes the last slot
          if (!(free_slots > CW'(1))) state_q <= StStall;
        end
      end
      // Count is registered, so a pop this cycle only frees the slot next cycle
      if (state_q == StStall && can_start) state_q <= StRun;
      if (rd_pend_q) asm_q <= {asm_q[15:0], mem_rdata};
    end
  end

`ifdef INST_PREFETCH_ALIGN_ERR_EN
  // One-cycle flag for a redirect target that is not word aligned
  always_ff @(posedge clk) begin
    if (rst) align_err <= 1'b0;
    else     align_err <= redirect && (redirect_pc[1:0] != 2'b00);
  end
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
`endif

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W + PC_W)
  ) u_inst_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({asm_q, mem_rdata, rd_pc_q}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: byte memory model, PC/word scoreboard, timing checks.
// Define INST_PREFETCH_ALIGN_ERR_EN to also exercise the align_err output.
module tb_inst_prefetch;

  logic        clk = 1'b0;
  logic        rst, redirect, inst_ready;
  logic [15:0] redirect_pc, mem_addr, inst_pc;
  logic        mem_rden, inst_valid;
  logic [7:0]  mem_rdata;
  logic [31:0] inst;

  logic        hi_redirect = 1'b0;
  logic [15:0] hi_redirect_pc = 16'h0000;
  logic        hi_ready = 1'b1;
  logic [15:0] hi_addr, hi_pc;
  logic        hi_rden, hi_valid;
  logic [7:0]  hi_rdata;
  logic [31:0] hi_inst;
`ifdef INST_PREFETCH_ALIGN_ERR_EN
  logic        align_err, hi_align_err;
`endif

  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;
  int rd_cnt = 0;
  int hi_n = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  inst_prefetch #(.DEPTH(4), .RESET_PC(16'h0000)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_addr    (mem_addr),
    .mem_rden    (mem_rden),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
`ifdef INST_PREFETCH_ALIGN_ERR_EN
    , .align_err (align_err)
`endif
  );

  inst_prefetch #(.DEPTH(4), .RESET_PC(16'hFFF8)) u_dut_hi (
    .clk         (clk),
    .rst         (rst),
    .redirect    (hi_redirect),
    .redirect_pc (hi_redirect_pc),
    .mem_addr    (hi_addr),
    .mem_rden    (hi_rden),
    .mem_rdata   (hi_rdata),
    .inst_valid  (hi_valid),
    .inst_ready  (hi_ready),
    .inst        (hi_inst),
    .inst_pc     (hi_pc)
`ifdef INST_PREFETCH_ALIGN_ERR_EN
    , .align_err (hi_align_err)
`endif
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h20;
      16'h0001: return 8'h08;
      16'h0002: return 8'h00;
      16'h0003: return 8'h05;
      default:  return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [15:0] pc);
    return {mem_byte(pc), mem_byte(pc + 16'd1), mem_byte(pc + 16'd2), mem_byte(pc + 16'd3)};
  endfunction

  // Byte memories: data valid one cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    mem_rdata <= mem_rden ? mem_byte(mem_addr) : 8'hEE;
    hi_rdata  <= hi_rden ? mem_byte(hi_addr) : 8'hEE;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_restart(input logic [15:0] pc);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(pc + 16'(4 * i));
  endtask

  // Scoreboard: every accepted instruction must be the next expected pc and its word
  always @(negedge clk) begin : sb_mon
    logic [31:0] e;
    if (!rst && inst_valid && inst_ready) begin
      e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h0001_0000;
      check_val("sb_pc", 32'(inst_pc), e);
      check_val("sb_inst", inst, word_at(e[15:0]));
      xfers <= xfers + 1;
    end
    if (mem_rden) rd_cnt <= rd_cnt + 1;
  end

  // Wrap-around DUT: first three words from FFF8
  always @(negedge clk) begin : hi_mon
    logic [15:0] e;
    if (!rst && hi_valid && hi_n < 3) begin
      case (hi_n)
        0:       e = 16'hFFF8;
        1:       e = 16'hFFFC;
        default: e = 16'h0000;
      endcase
      check_val("hi_pc", 32'(hi_pc), 32'(e));
      check_val("hi_inst", hi_inst, word_at(e));
      hi_n <= hi_n + 1;
    end
  end

  task automatic startup_check(input string tag);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_val({tag, "_rden0"}, 32'(mem_rden), 32'd1);
        check_val({tag, "_addr0"}, 32'(mem_addr), 32'h0000);
      end
      check_val({tag, "_valid"}, 32'(inst_valid), (c == 5) ? 32'd1 : 32'd0);
      if (c == 5) begin
        check_val({tag, "_inst"}, inst, 32'h2008_0005);
        check_val({tag, "_pc"}, 32'(inst_pc), 32'h0000);
      end
    end
  endtask

  task automatic wait_byte(input logic [1:0] idx, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (mem_rden && mem_addr[1:0] == idx) found = 1'b1;
    end
    check_val(tag, 32'(found), 32'd1);
  endtask

  task automatic do_redirect(input logic [15:0] pc, input logic rdy);
    logic [15:0] apc;
    apc = {pc[15:2], 2'b00};
    @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = pc; inst_ready = rdy;
    @(posedge clk);
    sb_restart(apc);
    #1 redirect = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_val("redir_rden1", 32'(mem_rden), 32'd1);
        check_val("redir_addr1", 32'(mem_addr), 32'(apc));
      end
      check_val("redir_valid", 32'(inst_valid), (c == 6) ? 32'd1 : 32'd0);
      if (c == 6) check_val("redir_pc6", 32'(inst_pc), 32'(apc));
`ifdef INST_PREFETCH_ALIGN_ERR_EN
      if (c == 1) check_val("align_err1", 32'(align_err), 32'(pc[1:0] != 2'b00));
      if (c == 2) check_val("align_err2", 32'(align_err), 32'd0);
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_base, x0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", 32'(inst_valid), 32'd0);
    check_val("rst_rden", 32'(mem_rden), 32'd0);
    check_val("rst_addr", 32'(mem_addr), 32'h0000);
    check_val("rst_inst", inst, 32'd0);
    check_val("rst_pc", 32'(inst_pc), 32'd0);
    check_val("rst_hi_addr", 32'(hi_addr), 32'h0000_FFF8);
    check_val("rst_hi_rden", 32'(hi_rden), 32'd0);
`ifdef INST_PREFETCH_ALIGN_ERR_EN
    check_val("rst_align_err", 32'(align_err), 32'd0);
`endif
    @(posedge clk);
    sb_restart(16'h0000);
    #1 rst = 1'b0;
    rd_base = rd_cnt;
    startup_check("start");

    // Consumer stalled: exactly DEPTH words buffered, memory idle, head held
    for (int c = 6; c <= 29; c++) begin
      @(negedge clk);
      if (c == 29) begin
        check_val("stall_rden", 32'(mem_rden), 32'd0);
        check_val("stall_valid", 32'(inst_valid), 32'd1);
        check_val("stall_pc", 32'(inst_pc), 32'h0000);
        check_val("stall_inst", inst, 32'h2008_0005);
      end
    end
    @(posedge clk);
    check_val("stall_reads", 32'(rd_cnt - rd_base), 32'd16);
    #1 inst_ready = 1'b1;
    x0 = xfers;
    repeat (5) @(posedge clk);
    check_val("drain_words", 32'(xfers - x0), 32'd4);
    repeat (40) @(posedge clk);

    // Redirect in the byte-2 slot of a word
    wait_byte(2'd1, "wait_byte1");
    do_redirect(16'h0040, 1'b1);
    repeat (20) @(posedge clk);

    // Redirect coinciding with a transfer
    #1 inst_ready = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 24 && !seen; i++) begin
        @(negedge clk);
        if (inst_valid) seen = 1'b1;
      end
      check_val("wait_valid", 32'(seen), 32'd1);
    end
    x0 = xfers;
    do_redirect(16'h0100, 1'b1);
    @(posedge clk);
    check_val("redir_xfer", 32'(xfers - x0), 32'd2);
    repeat (20) @(posedge clk);

    // Misaligned target: low bits dropped
    do_redirect(16'h0042, 1'b1);
    repeat (20) @(posedge clk);

    // Reset in the middle of a word
    wait_byte(2'd1, "wait_byte1_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_val("midrst_rden", 32'(mem_rden), 32'd0);
    @(posedge clk);
    sb_restart(16'h0000);
    #1 rst = 1'b0;
    startup_check("restart");
    repeat (20) @(posedge clk);

    check_val("hi_words", 32'(hi_n), 32'd3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
